data_memory_be: RTL

DATA_MEMORY_BE -- requirements
Module: data_memory_be

---
 rtl/data_memory_be.sv | 95 +++++++++
 1 files changed

// File: rtl/data_memory_be.sv
// Word-addressed memory with per-byte write enables, a clear-on-reset sequencer
// and a one-deep valid/ready response stage (1-cycle latency, full throughput).
module data_memory_be #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   read_data,
  output logic                rsp_err,
  output logic                init_done
);

  // state | meaning
  // INIT  | zeroing word clr_idx each cycle; requests ignored
  // RUN   | no response outstanding; any request is accepted
  // HOLD  | response outstanding; a new request is taken only as it retires

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {INIT, RUN, HOLD} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  word_idx;

  // Range check on the full address so high bits cannot alias into the array.
  assign in_range  = {1'b0, address} < DEPTH_EXT;
  assign word_idx  = address[IDX_W-1:0];
  assign req_ready = (state == RUN) || ((state == HOLD) && rsp_ready);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == HOLD);
  assign init_done = (state != INIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= INIT;
      clr_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) clr_idx <= clr_idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (clr_idx == LAST_IDX) state_nxt = RUN;
      RUN:     if (accept) state_nxt = HOLD;
      HOLD:    if (rsp_ready && !accept) state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clr_idx] <= '0;
    end else if (accept && req_write && in_range) begin
      for (int b = 0; b < BYTES; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= write_data[8*b +: 8];
      end
    end
  end

  // Read data is captured before the same-edge write lands, but writes return 0 anyway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_err   <= !in_range;
      read_data <= (!req_write && in_range) ? mem[word_idx] : '0;
    end else if ((state == HOLD) && rsp_ready) begin
      read_data <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule
